// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART baud-rate tick generator.
//   BAUD_DIV_W / BAUD_FRAC_W : default divisor field widths
//   baud_cfg_t               : {integer divisor, fractional divisor}
//   BAUD_MIN_DIV             : smallest usable integer divisor (keeps ticks
//                              at least two cycles apart)
//   baud_default_div()       : integer clocks per sample period for a rate
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int BAUD_DIV_W   = 16;
    localparam int BAUD_FRAC_W  = 4;
    localparam int BAUD_MIN_DIV = 2;

    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  div_int;
        logic [BAUD_FRAC_W-1:0] div_frac;
    } baud_cfg_t;

    function automatic int baud_default_div(input int sys_freq,
                                            input int baud,
                                            input int sample);
        return sys_freq / (sample * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen_frac_divider.sv
// ----------------------------------------------------------------------------
// uart_frac_divider
// Fractional cycle divider producing a one-cycle sample_tick every
// div_int + carry cycles, where carry is the overflow of a FRAC_W-bit
// phase accumulator stepped by div_frac on every tick.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : run; low holds counter, accumulator and tick at 0
//   clear         : realign phase to 0; suppresses a coinciding tick
//   acc_clear     : zero only the accumulator (new divisor took effect)
//   div_int       : integer clocks per sample period (>= 2)
//   div_frac      : fractional clocks per sample period, 1/2^FRAC_W units
//   sample_tick   : registered one-cycle tick
// ----------------------------------------------------------------------------
module uart_frac_divider #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              acc_clear,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              sample_tick
);

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              run;
    logic [FRAC_W:0]   frac_sum;
    logic [DIV_W:0]    period_m1;
    logic              last;

    assign frac_sum  = {1'b0, acc} + {1'b0, div_frac};
    // P - 1 needs DIV_W+1 bits of headroom for the sum, but the result never
    // exceeds 2^DIV_W - 1, so the DIV_W-bit counter can reach it.
    assign period_m1 = {1'b0, div_int} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]}
                     - {{DIV_W{1'b0}}, 1'b1};
    assign last      = ({1'b0, cnt} == period_m1);

    // The first enabled edge (run low) only arms the counter, so that the
    // first tick lands exactly P cycles after enable is seen, the same
    // distance as after a clear or after a previous tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            acc         <= '0;
            run         <= 1'b0;
            sample_tick <= 1'b0;
        end else if (!enable) begin
            cnt         <= '0;
            acc         <= '0;
            run         <= 1'b0;
            sample_tick <= 1'b0;
        end else if (clear) begin
            cnt         <= '0;
            acc         <= '0;
            run         <= 1'b1;
            sample_tick <= 1'b0;
        end else if (!run) begin
            run         <= 1'b1;
            sample_tick <= 1'b0;
            if (acc_clear) acc <= '0;
        end else if (last) begin
            cnt         <= '0;
            acc         <= acc_clear ? '0 : frac_sum[FRAC_W-1:0];
            sample_tick <= 1'b1;
        end else begin
            cnt         <= cnt + DIV_W'(1);
            sample_tick <= 1'b0;
            if (acc_clear) acc <= '0;
        end
    end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_tick_gen
// Runtime-programmable UART baud tick generator (clock enables, not clocks).
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   enable        : run the generator; low holds counters and ticks at 0
//   restart       : one-cycle request to realign the bit phase to 0
//   cfg_valid     : new divisor offered on cfg_div_int / cfg_div_frac
//   cfg_ready     : no config pending, an offer will be accepted
//   sample_tick   : one pulse per sample period
//   mid_tick      : SAMPLE/2-th sample tick of each bit
//   bit_tick      : every SAMPLE-th sample tick (bit boundary)
//   act_div_int   : integer divisor currently in use
// A new divisor is held pending and switched in only at a bit boundary,
// while disabled, or on restart, so a running bit never changes rate.
// ----------------------------------------------------------------------------
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int SYS_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int SAMPLE    = 16,
    parameter int DIV_W     = BAUD_DIV_W,
    parameter int FRAC_W    = BAUD_FRAC_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic              cfg_valid,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_ready,
    output logic              sample_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [DIV_W-1:0]  act_div_int
);

    localparam int               SCNT_W    = $clog2(SAMPLE);
    localparam logic [DIV_W-1:0] RESET_DIV =
        DIV_W'(baud_default_div(SYS_FREQ, BAUD_RATE, SAMPLE));

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(BAUD_MIN_DIV)) ? DIV_W'(BAUD_MIN_DIV) : d;
    endfunction

    baud_cfg_t         act_cfg;
    baud_cfg_t         pend_cfg;
    logic              pend_vld;
    logic [SCNT_W-1:0] scnt;
    logic              accept;
    logic              apply;

    uart_frac_divider #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear       (restart),
        .acc_clear   (apply),
        .div_int     (act_cfg.div_int),
        .div_frac    (act_cfg.div_frac),
        .sample_tick (sample_tick)
    );

    // scnt still holds the pre-increment value during the tick cycle, so the
    // bit/mid qualifiers line up with sample_tick with no extra latency.
    assign bit_tick    = sample_tick & (scnt == SCNT_W'(SAMPLE - 1));
    assign mid_tick    = sample_tick & (scnt == SCNT_W'(SAMPLE / 2 - 1));
    assign cfg_ready   = ~pend_vld;
    assign act_div_int = act_cfg.div_int;

    assign accept = cfg_valid & ~pend_vld;
    // Applying on the edge that ends the bit_tick cycle still governs the
    // whole next interval: the divider cannot end an interval on that edge.
    assign apply  = pend_vld & (bit_tick | ~enable | restart);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_cfg  <= '{div_int: RESET_DIV, div_frac: '0};
            pend_cfg <= '0;
            pend_vld <= 1'b0;
            scnt     <= '0;
        end else begin
            if (!enable || restart) begin
                scnt <= '0;
            end else if (sample_tick) begin
                scnt <= scnt + SCNT_W'(1);
            end

            if (apply) begin
                act_cfg  <= pend_cfg;
                pend_vld <= 1'b0;
            end else if (accept) begin
                pend_cfg <= '{div_int: clamp_div(cfg_div_int), div_frac: cfg_div_frac};
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_baud_tick_gen.md
# uart_baud_tick_gen

Runtime-programmable UART baud-rate generator that produces single-cycle tick enables. It does not produce divided clocks. A fractional divider yields an oversampling tick, a bit-boundary tick and a mid-bit tick. UART TX and RX consume these ticks as clock enables in the `clk` domain. The block adds a config handshake, glitch-free rate change on bit boundaries, and a restart input for RX start-bit alignment.

## Interface
Parameters:
- `SYS_FREQ`, 100000000: system clock in Hz; used only for the reset divisor.
- `BAUD_RATE`, 9600: reset-time baud rate.
- `SAMPLE`, 16: oversampling ratio; power of 2, at least 4.
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 4: fractional divisor width.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run the generator; low holds all counters at 0.
- `restart` in 1: one-cycle request to realign phase to 0.
- `cfg_valid` in 1: a new divisor is offered.
- `cfg_div_int` in `DIV_W`: integer clocks per sample period.
- `cfg_div_frac` in `FRAC_W`: fractional part, in units of 1/2^`FRAC_W`.
- `cfg_ready` out 1: a config can be accepted (no pending config).
- `sample_tick` out 1: one-cycle pulse per sample period.
- `mid_tick` out 1: coincides with the (`SAMPLE`/2)-th `sample_tick` of each bit.
- `bit_tick` out 1: coincides with every `SAMPLE`-th `sample_tick`.
- `act_div_int` out `DIV_W`: active integer divisor (readback).

## Operation
- Reset values:
  - All ticks are 0 and `cfg_ready` is 1.
  - Active divisor is `SYS_FREQ`/(`SAMPLE`·`BAUD_RATE`) (integer division), fraction 0.
  - Cycle counter, sample counter and accumulator are 0; no config is pending.
- Period rule: each sample interval lasts P = div_int + carry cycles.
  - carry is the carry-out of acc + div_frac, computed in `FRAC_W`+1 bits.
  - acc takes the `FRAC_W`-bit sum at each `sample_tick`.
- Divisor clamp: div_int values below 2 are clamped to 2 when accepted; `act_div_int` shows the clamped value.
- Sample counter: width log2(`SAMPLE`); increments on each `sample_tick` and wraps at `SAMPLE`-1→0.
  - `bit_tick` fires on the tick where the counter wraps.
  - `mid_tick` fires on the tick where the counter goes from `SAMPLE`/2-1 to `SAMPLE`/2.
- Config handshake:
  - Acceptance happens when `cfg_valid` and `cfg_ready` are both high; the value goes to a pending register and `cfg_ready` drops.
  - Pending is applied on the next `bit_tick`, or on the next cycle if `enable` is 0, or on `restart`.
  - `cfg_ready` rises the cycle after the pending config is applied.
  - If acceptance and `bit_tick` occur in the same cycle, the new config waits for the following boundary.
  - On apply, acc clears to 0.
- `restart`: on the next edge it clears the cycle counter, sample counter and acc, and applies any pending config. Restart outranks a coinciding tick: no tick is issued that cycle.
- `enable` low: counters, acc and ticks are held at 0; config acceptance still works.
- Reset mid-operation: all state returns to the reset values immediately; any pending config is lost.

## Timing
- Ticks are registered, high for exactly one `clk` cycle and never back-to-back, because P ≥ 2.
- First `sample_tick` is high P cycles after the edge that first samples `enable`=1 or `restart`=1. Each later tick follows P cycles after the previous one.
- `bit_tick` and `mid_tick` are asserted in the same cycle as their `sample_tick`, with zero added latency.
- A config applied on a `bit_tick` governs the interval starting right after that tick.
- Counter width: the cycle counter is `DIV_W` bits. The maximum P is 2^`DIV_W`, so the count fits.

## Structure
- Shared package `uart_pkg`:
  - Typedef `baud_cfg_t`: struct {div_int[`DIV_W`], div_frac[`FRAC_W`]}.
  - Constant `BAUD_MIN_DIV` = 2.
  - Function `baud_default_div`(sys_freq, baud, sample).
- Sub-module `uart_frac_divider` contains the cycle counter and fractional accumulator.
  - Inputs: `clk`, `reset_n`, `enable`, `clear`, div_int, div_frac.
  - Output: `sample_tick`.
- The top level holds the sample counter, the pending/active config registers and the handshake.

## Test plan
- Reset, then `enable`=1 with defaults (100 MHz, 9600, 16): `act_div_int`=651. `sample_tick` every 651 cycles; `bit_tick` every 10416 cycles; `mid_tick` 5208 cycles after each `bit_tick`.
- Config div_int=10, div_frac=8 (`FRAC_W`=4), then restart: sample intervals are 10, 11, 10, 11…; `bit_tick` every 168 cycles.
- Config div_int=20 offered mid-bit: `cfg_ready` drops the next cycle. The old period holds until `bit_tick`, then 20-cycle intervals begin. `cfg_ready` rises one cycle after that `bit_tick`.
- `restart` pulsed 5 cycles before an expected `sample_tick` (div 10): no tick at the old time. Next tick comes 10 cycles after the restart edge; `mid_tick` follows after 8 sample ticks.
- Config div_int=0 and div_int=1: `act_div_int` reads 2; ticks every 2 cycles, never adjacent.
- `reset_n` asserted mid-bit with a pending config: all outputs are 0 and `cfg_ready` is 1 asynchronously. `act_div_int` returns to 651.
